// File: rtl/osc_pkg.sv
// Shared types and constants for the oscilloscope acquisition controller.
//   osc_acq_st_t : acquisition state (IDLE, PRE, ARM, PST)
//   CW_DEF       : default width of the beat counters and length configuration
package osc_pkg;

  localparam int CW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ARM  = 2'd2,
    PST  = 2'd3
  } osc_acq_st_t;

endpackage

// File: rtl/osc_acq_cnt.sv
// Beat counter shared by the PRE and PST phases of osc_acq.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : increment by one (wraps at 2**CW)
//   cmp      : compare value
//   cnt      : current count
//   hit      : the increment about to be applied makes cnt equal cmp
module osc_acq_cnt
  import osc_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] cmp,
  output logic [CW-1:0] cnt,
  output logic          hit
);

  // Look-ahead compare so the FSM can act on the very beat that reaches cmp.
  assign hit = ((cnt + CW'(1)) == cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/osc_acq.sv
// Acquisition control stage behind the trigger detector. Gates the sample
// stream into records of cfg_pre pre-trigger beats, the trigger beat and
// cfg_pst post-trigger beats, closing each record with TLAST.
//   ACLK, ARESET        : clock, asynchronous active-high reset
//   ctl_rst             : synchronous clear of state, counter and output beat
//   ctl_str / ctl_stp   : start / stop acquisition pulses (stop wins)
//   ctl_trg             : trigger qualifier for the current sti beat
//   cfg_con             : re-arm after each record
//   cfg_pre / cfg_pst   : pre-trigger / post-trigger beat counts
//   sts_run / sts_arm   : state != IDLE / state == ARM
//   sts_trg / sts_end   : trigger accepted / TLAST beat transferred (pulses)
//   sts_cnt             : current PRE or PST counter value
//   sti_t*              : input stream (sink side: tdata, tvalid, tready)
//   sto_t*              : output stream (source side: tdata, tvalid, tready, tlast)
// The sti/sto stream bundles are carried as flat AXI4-Stream signals.
module osc_acq
  import osc_pkg::*;
#(
  parameter int  DN = 1,
  parameter type DT = logic signed [16-1:0],
  parameter int  CW = CW_DEF
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          ctl_rst,
  input  logic          ctl_str,
  input  logic          ctl_stp,
  input  logic          ctl_trg,
  input  logic          cfg_con,
  input  logic [CW-1:0] cfg_pre,
  input  logic [CW-1:0] cfg_pst,
  output logic          sts_run,
  output logic          sts_arm,
  output logic          sts_trg,
  output logic          sts_end,
  output logic [CW-1:0] sts_cnt,
  input  DT             sti_tdata,
  input  logic          sti_tvalid,
  output logic          sti_tready,
  output DT             sto_tdata,
  output logic          sto_tvalid,
  input  logic          sto_tready,
  output logic          sto_tlast
);

  if (DN != 1) begin : g_dn_check
    $error("osc_acq supports a single stream lane only");
  end

  osc_acq_st_t   st, st_nxt, st_start;
  logic          run, xfer, fwd, trg_acc, rec_end;
  logic          cnt_clr, cnt_en, cnt_hit;
  logic [CW-1:0] cnt, cnt_cmp;

  assign run        = (st != IDLE);
  assign sti_tready = run ? (sto_tready | ~sto_tvalid) : 1'b1;
  assign xfer       = sti_tvalid & sti_tready;
  assign fwd        = xfer & run & ~ctl_stp & ~ctl_rst;
  assign trg_acc    = fwd & (st == ARM) & ctl_trg;
  assign rec_end    = (fwd & (st == PST) & cnt_hit) | (trg_acc & (cfg_pst == '0));
  assign cnt_cmp    = (st == PRE) ? cfg_pre : cfg_pst;
  // A zero pre-trigger length skips PRE both at start and on continuous re-arm.
  assign st_start   = (cfg_pre == '0) ? ARM : PRE;
  assign sts_cnt    = cnt;

  osc_acq_cnt #(.CW(CW)) u_cnt (
    .clk (ACLK),
    .rst (ARESET),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cmp (cnt_cmp),
    .cnt (cnt),
    .hit (cnt_hit)
  );

  always_comb begin
    st_nxt  = st;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (ctl_rst) begin
      st_nxt  = IDLE;
      cnt_clr = 1'b1;
    end else if (ctl_stp) begin
      st_nxt = IDLE;
    end else begin
      unique case (st)
        IDLE: begin
          if (ctl_str) begin
            st_nxt  = st_start;
            cnt_clr = 1'b1;
          end
        end
        PRE: begin
          if (fwd) begin
            cnt_en = 1'b1;
            if (cnt_hit) st_nxt = ARM;
          end
        end
        ARM: begin
          if (trg_acc) begin
            cnt_clr = 1'b1;
            if (cfg_pst == '0) st_nxt = cfg_con ? st_start : IDLE;
            else               st_nxt = PST;
          end
        end
        PST: begin
          if (fwd) begin
            cnt_en = 1'b1;
            if (cnt_hit) begin
              st_nxt  = cfg_con ? st_start : IDLE;
              cnt_clr = cfg_con;
            end
          end
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      st         <= IDLE;
      sts_run    <= 1'b0;
      sts_arm    <= 1'b0;
      sts_trg    <= 1'b0;
      sts_end    <= 1'b0;
      sto_tvalid <= 1'b0;
      sto_tlast  <= 1'b0;
      sto_tdata  <= '0;
    end else if (ctl_rst) begin
      st         <= IDLE;
      sts_run    <= 1'b0;
      sts_arm    <= 1'b0;
      sts_trg    <= 1'b0;
      sts_end    <= 1'b0;
      sto_tvalid <= 1'b0;
      sto_tlast  <= 1'b0;
      sto_tdata  <= '0;
    end else begin
      st      <= st_nxt;
      sts_run <= (st_nxt != IDLE);
      sts_arm <= (st_nxt == ARM);
      sts_trg <= trg_acc;
      sts_end <= sto_tvalid & sto_tready & sto_tlast;
      // A held beat survives a stop; it only leaves through the handshake.
      if (fwd) begin
        sto_tvalid <= 1'b1;
        sto_tdata  <= sti_tdata;
        sto_tlast  <= rec_end;
      end else if (sto_tready) begin
        sto_tvalid <= 1'b0;
        sto_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_osc_acq.sv
module tb_osc_acq;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        ctl_rst = 1'b0, ctl_str = 1'b0, ctl_stp = 1'b0, ctl_trg = 1'b0;
  logic        cfg_con = 1'b0;
  logic [31:0] cfg_pre = '0, cfg_pst = '0;
  logic        sts_run, sts_arm, sts_trg, sts_end;
  logic [31:0] sts_cnt;
  logic [15:0] sti_tdata = '0;
  logic        sti_tvalid = 1'b0;
  logic        sti_tready;
  logic [15:0] sto_tdata;
  logic        sto_tvalid, sto_tlast;
  logic        sto_tready = 1'b1;

  always #5 clk = ~clk;

  osc_acq #(.DN(1), .DT(logic signed [15:0]), .CW(32)) dut (
    .ACLK(clk), .ARESET(arst), .ctl_rst(ctl_rst), .ctl_str(ctl_str),
    .ctl_stp(ctl_stp), .ctl_trg(ctl_trg), .cfg_con(cfg_con),
    .cfg_pre(cfg_pre), .cfg_pst(cfg_pst), .sts_run(sts_run),
    .sts_arm(sts_arm), .sts_trg(sts_trg), .sts_end(sts_end),
    .sts_cnt(sts_cnt), .sti_tdata(sti_tdata), .sti_tvalid(sti_tvalid),
    .sti_tready(sti_tready), .sto_tdata(sto_tdata), .sto_tvalid(sto_tvalid),
    .sto_tready(sto_tready), .sto_tlast(sto_tlast)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] d;
    logic        l;
  } beat_t;
  typedef enum {P_IDLE, P_PRE, P_ARM, P_PST} phase_t;

  beat_t       q[$];           // beats the output must still deliver, in order
  phase_t      ph = P_IDLE;
  logic [31:0] m_cnt = '0;
  logic        m_trg = 1'b0, m_end = 1'b0;

  function automatic void m_start();
    m_cnt = '0;
    ph    = (cfg_pre == 0) ? P_ARM : P_PRE;
  endfunction

  function automatic void m_finish();
    if (cfg_con) m_start();
    else         ph = P_IDLE;
  endfunction

  function automatic void m_push(logic [15:0] d, logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    q.push_back(b);
  endfunction

  always @(posedge clk or posedge arst) begin
    logic  rdy, xfer;
    beat_t b;
    if (arst) begin
      q.delete();
      ph = P_IDLE; m_cnt = '0; m_trg = 1'b0; m_end = 1'b0;
    end else begin
      rdy   = (ph != P_IDLE) ? (sto_tready || q.size() == 0) : 1'b1;
      xfer  = sti_tvalid && rdy;
      m_trg = 1'b0;
      m_end = 1'b0;
      if (q.size() != 0 && sto_tready) begin
        b = q.pop_front();
        m_end = b.l;
      end
      if (ctl_rst) begin
        q.delete();
        ph = P_IDLE; m_cnt = '0; m_end = 1'b0;
      end else if (ctl_stp) begin
        ph = P_IDLE;
      end else begin
        case (ph)
          P_IDLE: if (ctl_str) m_start();
          P_PRE: if (xfer) begin
            m_push(sti_tdata, 1'b0);
            m_cnt = m_cnt + 1;
            if (m_cnt == cfg_pre) ph = P_ARM;
          end
          P_ARM: if (xfer) begin
            if (ctl_trg) begin
              m_trg = 1'b1;
              m_cnt = '0;
              if (cfg_pst == 0) begin
                m_push(sti_tdata, 1'b1);
                m_finish();
              end else begin
                m_push(sti_tdata, 1'b0);
                ph = P_PST;
              end
            end else begin
              m_push(sti_tdata, 1'b0);
            end
          end
          P_PST: if (xfer) begin
            m_cnt = m_cnt + 1;
            m_push(sti_tdata, m_cnt == cfg_pst);
            if (m_cnt == cfg_pst) m_finish();
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- compare process ----------------
  beat_t seen[$];
  logic  logging = 1'b0;
  int    n_end = 0, n_trg = 0;

  always @(negedge clk) begin
    chk("tvalid", sto_tvalid, q.size() != 0);
    if (q.size() != 0) begin
      chk("tdata", sto_tdata, q[0].d);
      chk("tlast", sto_tlast, q[0].l);
    end
    chk("tready", sti_tready, (ph != P_IDLE) ? (sto_tready || q.size() == 0) : 1'b1);
    chk("sts_run", sts_run, ph != P_IDLE);
    chk("sts_arm", sts_arm, ph == P_ARM);
    chk("sts_trg", sts_trg, m_trg);
    chk("sts_end", sts_end, m_end);
    chk("sts_cnt", sts_cnt, m_cnt);
    if (logging && sto_tvalid && sto_tready) begin
      beat_t b;
      b.d = sto_tdata;
      b.l = sto_tlast;
      seen.push_back(b);
    end
    if (sts_end) n_end++;
    if (sts_trg) n_trg++;
  end

  // ---------------- output-side backpressure ----------------
  int bp_mode = 0;  // 0: always ready, 1: toggle 1010..., 2: random
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       sto_tready = 1'b1;
      1:       sto_tready = ~sto_tready;
      default: sto_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    sti_tvalid = 1'b0;
    ctl_trg    = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [15:0] d, input logic t);
    logic ok;
    ok         = 1'b0;
    sti_tvalid = 1'b1;
    sti_tdata  = d;
    ctl_trg    = t;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = sti_tready;
      step();
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    ctl_trg = 1'b0;
  endtask

  task automatic ramp(int n, logic [63:0] tmask);
    for (int k = 0; k < n; k++) send(16'(k), tmask[k]);
    sti_tvalid = 1'b0;
  endtask

  task automatic begin_rec(int pre, int pst, logic con);
    cfg_pre = 32'(pre);
    cfg_pst = 32'(pst);
    cfg_con = con;
    seen.delete();
    n_end = 0; n_trg = 0;
    logging = 1'b1;
    ctl_str = 1'b1;
    step();
    ctl_str = 1'b0;
  endtask

  task automatic check_ramp(string nm, int len, logic [63:0] lmask);
    chk({nm, "_len"}, 64'(seen.size()), 64'(len));
    for (int i = 0; i < len && i < seen.size(); i++) begin
      chk({nm, "_data"}, seen[i].d, 16'(i));
      chk({nm, "_last"}, seen[i].l, lmask[i]);
    end
  endtask

  initial begin
    repeat (3) step();
    arst = 1'b0;
    step();
    chk("reset_tvalid", sto_tvalid, 0);
    chk("reset_run", sts_run, 0);
    chk("reset_cnt", sts_cnt, 0);

    // basic record: trigger on beat 2 ignored, beat 10 accepted
    begin_rec(4, 3, 1'b0);
    ramp(20, 64'h404);
    idle(4);
    check_ramp("basic", 14, 64'h2000);
    chk("basic_nend", 64'(n_end), 1);
    chk("basic_ntrg", 64'(n_trg), 1);
    chk("basic_idle", sts_run, 0);

    // trigger on the completing PRE beat is ignored, next beat accepted
    begin_rec(4, 3, 1'b0);
    ramp(12, 64'h18);
    idle(4);
    check_ramp("bound", 8, 64'h80);

    // zero lengths: one-beat record
    begin_rec(0, 0, 1'b0);
    ramp(3, 64'h1);
    idle(4);
    check_ramp("zero", 1, 64'h1);
    chk("zero_nend", 64'(n_end), 1);

    // backpressure 1010... on the basic record
    bp_mode = 1;
    begin_rec(4, 3, 1'b0);
    ramp(20, 64'h404);
    idle(6);
    check_ramp("bp", 14, 64'h2000);
    bp_mode = 0;
    idle(2);

    // continuous mode, trigger every 10 beats
    begin_rec(4, 3, 1'b1);
    ramp(40, 64'h0000_0080_2008_0200);
    ctl_stp = 1'b1;
    step();
    ctl_stp = 1'b0;
    idle(4);
    check_ramp("cont", 40, 64'h0000_0001_0040_1000);
    chk("cont_nend", 64'(n_end), 3);

    // stop after one post-trigger beat
    begin_rec(4, 3, 1'b0);
    ramp(12, 64'h400);
    ctl_stp = 1'b1;
    step();
    ctl_stp = 1'b0;
    chk("abort_run", sts_run, 0);
    idle(4);
    check_ramp("abort", 12, 64'h0);
    chk("abort_nend", 64'(n_end), 0);

    // asynchronous reset mid-record
    begin_rec(4, 3, 1'b0);
    ramp(6, 64'h0);
    chk("pre_arst_tvalid", sto_tvalid, 1);
    arst = 1'b1;
    #1;
    chk("arst_tvalid", sto_tvalid, 0);
    chk("arst_tlast", sto_tlast, 0);
    chk("arst_tdata", sto_tdata, 0);
    chk("arst_run", sts_run, 0);
    chk("arst_cnt", sts_cnt, 0);
    step();
    arst = 1'b0;
    logging = 1'b0;
    step();

    // randomized traffic against the model
    bp_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        cfg_pre = 32'($urandom_range(0, 5));
        cfg_pst = 32'($urandom_range(0, 5));
        cfg_con = 1'($urandom_range(0, 1));
      end
      sti_tvalid = ($urandom_range(0, 3) != 0);
      sti_tdata  = 16'($urandom);
      ctl_trg    = ($urandom_range(0, 4) == 0);
      ctl_str    = ($urandom_range(0, 7) == 0);
      ctl_stp    = ($urandom_range(0, 59) == 0);
      ctl_rst    = ($urandom_range(0, 199) == 0);
      step();
    end
    ctl_str = 1'b0; ctl_stp = 1'b0; ctl_rst = 1'b0;
    bp_mode = 0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
